// File: rtl/sap_control_sequencer.sv
// Microcoded T0-T4 control sequencer for the SAP 8-bit datapath.
// Optional macro SEQ_EARLY_RESET_EN: return to T0 right after each opcode's last active step.
module sap_control_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] opcode,
    input  logic [1:0] flags,
    output logic       co_n,
    output logic       ro_n,
    output logic       io_n,
    output logic       ao_n,
    output logic       eo_n,
    output logic       mi_n,
    output logic       ii_n,
    output logic       ai_n,
    output logic       bi_n,
    output logic       fi_n,
    output logic       j_n,
    output logic       ri,
    output logic       oi,
    output logic       ce,
    output logic       su,
    output logic       hlt,
    output logic [2:0] step
);

    localparam int unsigned STEP_W = 3;

    typedef enum logic [STEP_W-1:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4
    } step_t;

    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    step_t step_q;
    step_t step_inc;
    step_t last_step;
    logic  halted;

    // Final micro-step of the current instruction before wrapping to T0.
    always_comb begin
`ifdef SEQ_EARLY_RESET_EN
        case (opcode)
            OP_LDI, OP_JMP, OP_JC, OP_JZ, OP_OUT, OP_HLT: last_step = T2;
            OP_LDA, OP_STA:                               last_step = T3;
            OP_ADD, OP_SUB:                               last_step = T4;
            default:                                      last_step = T1;
        endcase
`else
        last_step = T4;
`endif
    end

    always_comb begin
        case (step_q)
            T0:      step_inc = T1;
            T1:      step_inc = T2;
            T2:      step_inc = T3;
            T3:      step_inc = T4;
            default: step_inc = T0;
        endcase
    end

    // Step counter; HLT in T2 freezes the counter until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            step_q <= T0;
            halted <= 1'b0;
        end else if (!halted) begin
            if (step_q == T2 && opcode == OP_HLT) begin
                halted <= 1'b1;
            end else if (step_q == last_step) begin
                step_q <= T0;
            end else begin
                step_q <= step_inc;
            end
        end
    end

    // Control word decode; reset forces every line inactive, including hlt.
    always_comb begin
        co_n = 1'b1;
        ro_n = 1'b1;
        io_n = 1'b1;
        ao_n = 1'b1;
        eo_n = 1'b1;
        mi_n = 1'b1;
        ii_n = 1'b1;
        ai_n = 1'b1;
        bi_n = 1'b1;
        fi_n = 1'b1;
        j_n  = 1'b1;
        ri   = 1'b0;
        oi   = 1'b0;
        ce   = 1'b0;
        su   = 1'b0;
        hlt  = 1'b0;
        if (!rst) begin
            if (halted) begin
                hlt = 1'b1;
            end else begin
                case (step_q)
                    T0: begin
                        co_n = 1'b0;
                        mi_n = 1'b0;
                    end
                    T1: begin
                        ro_n = 1'b0;
                        ii_n = 1'b0;
                        ce   = 1'b1;
                    end
                    T2: begin
                        case (opcode)
                            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                                io_n = 1'b0;
                                mi_n = 1'b0;
                            end
                            OP_LDI: begin
                                io_n = 1'b0;
                                ai_n = 1'b0;
                            end
                            OP_JMP: begin
                                io_n = 1'b0;
                                j_n  = 1'b0;
                            end
                            OP_JC: begin
                                io_n = 1'b0;
                                j_n  = ~flags[0];
                            end
                            OP_JZ: begin
                                io_n = 1'b0;
                                j_n  = ~flags[1];
                            end
                            OP_OUT: begin
                                ao_n = 1'b0;
                                oi   = 1'b1;
                            end
                            OP_HLT: hlt = 1'b1;
                            default: ;
                        endcase
                    end
                    T3: begin
                        case (opcode)
                            OP_LDA: begin
                                ro_n = 1'b0;
                                ai_n = 1'b0;
                            end
                            OP_ADD, OP_SUB: begin
                                ro_n = 1'b0;
                                bi_n = 1'b0;
                            end
                            OP_STA: begin
                                ao_n = 1'b0;
                                ri   = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                    T4: begin
                        if (opcode == OP_ADD || opcode == OP_SUB) begin
                            eo_n = 1'b0;
                            ai_n = 1'b0;
                            fi_n = 1'b0;
                            su   = (opcode == OP_SUB);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign step = step_q;

endmodule

// File: tb/tb_sap_control_sequencer.sv
// Bench for sap_control_sequencer: directed vector table, hand sequences, and
// randomized stimulus against a microcode-table reference model.
module tb_sap_control_sequencer;

    localparam logic [15:0] M_CO  = 16'h0001;
    localparam logic [15:0] M_RO  = 16'h0002;
    localparam logic [15:0] M_IO  = 16'h0004;
    localparam logic [15:0] M_AO  = 16'h0008;
    localparam logic [15:0] M_EO  = 16'h0010;
    localparam logic [15:0] M_MI  = 16'h0020;
    localparam logic [15:0] M_II  = 16'h0040;
    localparam logic [15:0] M_AI  = 16'h0080;
    localparam logic [15:0] M_BI  = 16'h0100;
    localparam logic [15:0] M_FI  = 16'h0200;
    localparam logic [15:0] M_J   = 16'h0400;
    localparam logic [15:0] M_RI  = 16'h0800;
    localparam logic [15:0] M_OI  = 16'h1000;
    localparam logic [15:0] M_CE  = 16'h2000;
    localparam logic [15:0] M_SU  = 16'h4000;
    localparam logic [15:0] M_HLT = 16'h8000;
    localparam logic [15:0] F0 = M_CO | M_MI;
    localparam logic [15:0] F1 = M_RO | M_II | M_CE;

    logic       clk;
    logic       rst;
    logic [3:0] opcode;
    logic [1:0] flags;
    logic co_n, ro_n, io_n, ao_n, eo_n, mi_n, ii_n, ai_n, bi_n, fi_n, j_n;
    logic ri, oi, ce, su, hlt;
    logic [2:0] step;
    logic [15:0] act;

    sap_control_sequencer dut (
        .clk(clk), .rst(rst), .opcode(opcode), .flags(flags),
        .co_n(co_n), .ro_n(ro_n), .io_n(io_n), .ao_n(ao_n), .eo_n(eo_n),
        .mi_n(mi_n), .ii_n(ii_n), .ai_n(ai_n), .bi_n(bi_n), .fi_n(fi_n), .j_n(j_n),
        .ri(ri), .oi(oi), .ce(ce), .su(su), .hlt(hlt), .step(step)
    );

    assign act = {hlt, su, ce, oi, ri, ~j_n, ~fi_n, ~bi_n, ~ai_n, ~ii_n, ~mi_n,
                  ~eo_n, ~ao_n, ~io_n, ~ro_n, ~co_n};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        r;
        logic [3:0]  op;
        logic [1:0]  fl;
        logic [2:0]  exp_step;
        logic [15:0] exp_act;
    } vec_t;

    vec_t        vecs[$];
    logic [15:0] ucode[16][5];
    int          ilen[16];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          m_step;
    bit          m_halted;

    task automatic add(input logic r, input logic [3:0] op, input logic [1:0] fl,
                       input logic [2:0] es, input logic [15:0] ea);
        vec_t v;
        v.r = r; v.op = op; v.fl = fl; v.exp_step = es; v.exp_act = ea;
        vecs.push_back(v);
    endtask

    // One cycle: wait for the edge, drive new inputs, let the decode settle.
    task automatic cyc(input logic r, input logic [3:0] op, input logic [1:0] fl);
        @(posedge clk);
        #1;
        rst = r; opcode = op; flags = fl;
        #1;
    endtask

    task automatic check(input string name, input logic [2:0] es, input logic [15:0] ea);
        n_cmp++;
        if (step !== es || act !== ea) begin
            n_bad++;
            $display("FAIL %s: got step=%0d word=%h, expected step=%0d word=%h",
                     name, step, act, es, ea);
        end
    endtask

    // Expected active-line mask from the microcode table.
    function automatic logic [15:0] model_word(input int s, input bit h, input logic r,
                                               input logic [3:0] op, input logic [1:0] fl);
        logic [15:0] w;
        if (r) return 16'h0000;
        if (h) return M_HLT;
        if (s == 0) return F0;
        if (s == 1) return F1;
        w = ucode[op][s];
        if (s == 2 && op == 4'h7 && fl[0]) w = w | M_J;
        if (s == 2 && op == 4'h8 && fl[1]) w = w | M_J;
        return w;
    endfunction

    // Advance the reference state across one clock edge.
    task automatic model_edge(input logic r, input logic [3:0] op);
        if (r) begin
            m_step = 0;
            m_halted = 1'b0;
        end else if (!m_halted) begin
            if (m_step == 2 && op == 4'hF) m_halted = 1'b1;
            else if (m_step >= ilen[op] - 1) m_step = 0;
            else m_step = m_step + 1;
        end
    endtask

    initial begin
        rst = 1'b1; opcode = 4'h2; flags = 2'b00;

        for (int o = 0; o < 16; o++) begin
            for (int s = 0; s < 5; s++) ucode[o][s] = 16'h0000;
`ifdef SEQ_EARLY_RESET_EN
            ilen[o] = 2;
`else
            ilen[o] = 5;
`endif
        end
        ucode[1][2] = M_IO | M_MI;  ucode[1][3] = M_RO | M_AI;
        ucode[2][2] = M_IO | M_MI;  ucode[2][3] = M_RO | M_BI;  ucode[2][4] = M_EO | M_AI | M_FI;
        ucode[3][2] = M_IO | M_MI;  ucode[3][3] = M_RO | M_BI;  ucode[3][4] = M_EO | M_AI | M_FI | M_SU;
        ucode[4][2] = M_IO | M_MI;  ucode[4][3] = M_AO | M_RI;
        ucode[5][2] = M_IO | M_AI;
        ucode[6][2] = M_IO | M_J;
        ucode[7][2] = M_IO;
        ucode[8][2] = M_IO;
        ucode[14][2] = M_AO | M_OI;
        ucode[15][2] = M_HLT;
`ifdef SEQ_EARLY_RESET_EN
        ilen[5] = 3; ilen[6] = 3; ilen[7] = 3; ilen[8] = 3; ilen[14] = 3; ilen[15] = 3;
        ilen[1] = 4; ilen[4] = 4; ilen[2] = 5; ilen[3] = 5;
`endif

        // Reset, fetch, SUB, then JZ/JC taken and not taken.
        add(1, 4'h2, 2'b00, 3'd0, 16'h0000);
        add(1, 4'h2, 2'b00, 3'd0, 16'h0000);
        add(0, 4'h2, 2'b00, 3'd0, F0);
        add(0, 4'h2, 2'b00, 3'd1, F1);
        add(0, 4'h3, 2'b00, 3'd2, M_IO | M_MI);
        add(0, 4'h3, 2'b00, 3'd3, M_RO | M_BI);
        add(0, 4'h3, 2'b00, 3'd4, M_EO | M_AI | M_FI | M_SU);
        add(0, 4'h3, 2'b00, 3'd0, F0);
        add(0, 4'h3, 2'b00, 3'd1, F1);
        add(0, 4'h8, 2'b10, 3'd2, M_IO | M_J);
`ifndef SEQ_EARLY_RESET_EN
        add(0, 4'h8, 2'b10, 3'd3, 16'h0000);
        add(0, 4'h8, 2'b10, 3'd4, 16'h0000);
`endif
        add(0, 4'h8, 2'b00, 3'd0, F0);
        add(0, 4'h8, 2'b01, 3'd1, F1);
        add(0, 4'h8, 2'b01, 3'd2, M_IO);
`ifndef SEQ_EARLY_RESET_EN
        add(0, 4'h8, 2'b01, 3'd3, 16'h0000);
        add(0, 4'h8, 2'b01, 3'd4, 16'h0000);
`endif
        add(0, 4'h8, 2'b01, 3'd0, F0);
        add(0, 4'h8, 2'b01, 3'd1, F1);
        add(0, 4'h7, 2'b01, 3'd2, M_IO | M_J);
`ifndef SEQ_EARLY_RESET_EN
        add(0, 4'h7, 2'b01, 3'd3, 16'h0000);
        add(0, 4'h7, 2'b01, 3'd4, 16'h0000);
`endif
        add(0, 4'h7, 2'b01, 3'd0, F0);
        add(0, 4'h7, 2'b10, 3'd1, F1);
        add(0, 4'h7, 2'b10, 3'd2, M_IO);

        // The first edge at t=5 samples rst=1.
        foreach (vecs[i]) begin
            if (i == 0) begin
                @(posedge clk);
                #2;
            end else begin
                cyc(vecs[i].r, vecs[i].op, vecs[i].fl);
            end
            check($sformatf("vec%0d", i), vecs[i].exp_step, vecs[i].exp_act);
        end

        // HLT: frozen in T2 with hlt=1 until a reset pulse.
        cyc(1, 4'hF, 2'b00);
        cyc(0, 4'hF, 2'b00); check("hlt_t0", 3'd0, F0);
        cyc(0, 4'hF, 2'b00); check("hlt_t1", 3'd1, F1);
        cyc(0, 4'hF, 2'b00); check("hlt_t2", 3'd2, M_HLT);
        for (int i = 0; i < 12; i++) begin
            cyc(0, 4'hF, 2'($urandom_range(0, 3)));
            check($sformatf("hlt_hold%0d", i), 3'd2, M_HLT);
        end
        cyc(1, 4'hF, 2'b00); check("hlt_rst_in", 3'd2, 16'h0000);
        cyc(0, 4'hF, 2'b00); check("hlt_rst_out", 3'd0, F0);

        // LDI step sequence.
        cyc(1, 4'h5, 2'b00);
        cyc(0, 4'h5, 2'b00); check("ldi_t0", 3'd0, F0);
        cyc(0, 4'h5, 2'b00); check("ldi_t1", 3'd1, F1);
        cyc(0, 4'h5, 2'b00); check("ldi_t2", 3'd2, M_IO | M_AI);
`ifndef SEQ_EARLY_RESET_EN
        cyc(0, 4'h5, 2'b00); check("ldi_t3", 3'd3, 16'h0000);
        cyc(0, 4'h5, 2'b00); check("ldi_t4", 3'd4, 16'h0000);
`endif
        cyc(0, 4'h5, 2'b00); check("ldi_wrap", 3'd0, F0);

        // Reset during ADD T3 abandons the instruction.
        cyc(1, 4'h2, 2'b00);
        cyc(0, 4'h2, 2'b00); check("radd_t0", 3'd0, F0);
        cyc(0, 4'h2, 2'b00); check("radd_t1", 3'd1, F1);
        cyc(0, 4'h2, 2'b00); check("radd_t2", 3'd2, M_IO | M_MI);
        cyc(1, 4'h2, 2'b00); check("radd_t3_rst", 3'd3, 16'h0000);
        cyc(0, 4'h2, 2'b00); check("radd_after0", 3'd0, F0);
        cyc(0, 4'h2, 2'b00); check("radd_after1", 3'd1, F1);

        // Randomized run against the reference model.
        begin
            logic       r;
            logic [3:0] op;
            logic [1:0] fl;
            op = 4'h0;
            cyc(1, op, 2'b00);
            model_edge(1'b1, op);
            for (int i = 0; i < 3000; i++) begin
                r  = m_halted ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 49) == 0);
                fl = 2'($urandom_range(0, 3));
                if (m_step == 2 && !m_halted) op = 4'($urandom_range(0, 15));
                cyc(r, op, fl);
                check($sformatf("rand%0d", i), 3'(m_step), model_word(m_step, m_halted, r, op, fl));
                model_edge(r, op);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
